// File: rtl/day_pkg.sv
// Shared day codes, controller states and the modulo-7 day increment.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package day_pkg;

  localparam logic [2:0] DAY_MON  = 3'd0;
  localparam logic [2:0] DAY_TUE  = 3'd1;
  localparam logic [2:0] DAY_WED  = 3'd2;
  localparam logic [2:0] DAY_THU  = 3'd3;
  localparam logic [2:0] DAY_FRI  = 3'd4;
  localparam logic [2:0] DAY_SAT  = 3'd5;
  localparam logic [2:0] DAY_SUN  = 3'd6;
  localparam logic [2:0] DAY_LAST = 3'd6;

  localparam int NUM_LETTERS = 4;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  // Wraps SUN back to MON; an illegal code 7 also recovers to MON.
  function automatic logic [2:0] day_inc(input logic [2:0] d);
    return (d >= DAY_LAST) ? DAY_MON : d + 3'd1;
  endfunction

endpackage

// File: rtl/digit_scanner.sv
// Scans the four letter positions and blanks all digits on the blink phase.
// Latency: letter_pos/digit_en change one clock after a counter wrap.
// Backpressure: none; free-running counters.
module digit_scanner
  import day_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   blink_en,
  input  logic                   clear,
  output logic [1:0]             letter_pos,
  output logic [NUM_LETTERS-1:0] digit_en
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [NUM_LETTERS-1:0] ONE_HOT0 = NUM_LETTERS'(1);

  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Dwell counter; each wrap moves the scan to the next letter (mod 4).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt   <= '0;
      letter_pos <= 2'd0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt   <= '0;
      letter_pos <= letter_pos + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Blink half-period counter; clear wins so RUN always shows the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (clear) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_en) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Decoded straight from registers, so it moves with letter_pos and is never multi-hot.
  assign digit_en = blink_phase ? '0 : (ONE_HOT0 << letter_pos);

endmodule

// File: rtl/day_set_ctrl.sv
// Day-of-week register with midnight advance and a button-driven set mode.
// Latency: every output changes one clock after its causing input edge.
// Backpressure: none; ticks seen in SET are remembered as one pending advance.
module day_set_ctrl
  import day_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   midnight_tick,
  input  logic                   btn_mode,
  input  logic                   btn_inc,
  output logic [2:0]             day,
  output logic [1:0]             letter_pos,
  output logic [NUM_LETTERS-1:0] digit_en,
  output logic                   set_mode
);

  state_t     state, state_n;
  logic [2:0] day_n;
  logic       pending, pending_n;
  logic       mode_q, inc_q;
  logic       mode_edge, inc_edge;

  assign mode_edge = btn_mode & ~mode_q;
  assign inc_edge  = btn_inc & ~inc_q;

  // Previous button levels for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
    end
  end

  // State, day, pending flag and the registered set-mode indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      day      <= DAY_MON;
      pending  <= 1'b0;
      set_mode <= 1'b0;
    end else begin
      state    <= state_n;
      day      <= day_n;
      pending  <= pending_n;
      set_mode <= (state_n == ST_SET);
    end
  end

  // Next state; in SET an inc is applied before the exit's pending advance.
  always_comb begin
    state_n   = state;
    day_n     = day;
    pending_n = pending;
    case (state)
      ST_RUN: begin
        pending_n = 1'b0;
        if (midnight_tick) day_n = day_inc(day);
        if (mode_edge)     state_n = ST_SET;
      end
      ST_SET: begin
        if (inc_edge) day_n = day_inc(day);
        if (mode_edge) begin
          state_n   = ST_RUN;
          pending_n = 1'b0;
          if (pending || midnight_tick) day_n = day_inc(day_n);
        end else if (midnight_tick) begin
          pending_n = 1'b1;
        end
      end
      default: begin
        state_n   = ST_RUN;
        pending_n = 1'b0;
      end
    endcase
  end

  digit_scanner #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .blink_en   (state == ST_SET),
    .clear      (state_n == ST_RUN),
    .letter_pos (letter_pos),
    .digit_en   (digit_en)
  );

endmodule

// File: tb/tb_day_set_ctrl.sv
// Directed bench for day_set_ctrl with short scan/blink dividers.
// Latency: checks outputs on the falling edge after each driven cycle.
// Backpressure: n/a.
module tb_day_set_ctrl;

  logic       clk;
  logic       rst_n;
  logic       midnight_tick;
  logic       btn_mode;
  logic       btn_inc;
  logic [2:0] day;
  logic [1:0] letter_pos;
  logic [3:0] digit_en;
  logic       set_mode;

  int checks   = 0;
  int failures = 0;
  int cyc;

  typedef struct {
    logic       t;
    logic       m;
    logic       i;
    logic [2:0] d;
    logic       s;
  } vec_t;

  vec_t vq[$];

  day_set_ctrl #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .midnight_tick (midnight_tick),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .day           (day),
    .letter_pos    (letter_pos),
    .digit_en      (digit_en),
    .set_mode      (set_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; the scan position follows from it alone.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_scan(input bit blank);
    int p;
    logic [3:0] oh;
    p  = (cyc / 4) % 4;
    oh = 4'b0001 << p;
    chk("letter_pos", {6'd0, letter_pos}, p[7:0]);
    chk("digit_en", {4'd0, digit_en}, blank ? 8'd0 : {4'd0, oh});
  endtask

  task automatic drive(input logic t, input logic m, input logic i);
    midnight_tick = t;
    btn_mode      = m;
    btn_inc       = i;
    @(negedge clk);
  endtask

  task automatic add(input logic t, input logic m, input logic i,
                     input logic [2:0] d, input logic s);
    vec_t v;
    v.t = t; v.m = m; v.i = i; v.d = d; v.s = s;
    vq.push_back(v);
  endtask

  initial begin
    // Vectors start from RUN with day=0: {tick, mode, inc, day, set_mode}.
    // inc ignored in RUN, three incs in SET
    add(1,0,0,1,0); add(0,0,0,1,0); add(1,0,0,2,0); add(0,0,0,2,0);
    add(0,0,1,2,0); add(0,0,0,2,0); add(0,1,0,2,1); add(0,0,0,2,1);
    add(0,0,1,3,1); add(0,0,0,3,1); add(0,0,1,4,1); add(0,0,0,4,1);
    add(0,0,1,5,1); add(0,0,0,5,1); add(0,1,0,5,0); add(0,0,0,5,0);
    // wrap 6->0 in SET, three ticks saturate into one exit increment
    add(0,1,0,5,1); add(0,0,0,5,1); add(0,0,1,6,1); add(0,0,0,6,1);
    add(0,0,1,0,1); add(0,0,0,0,1); add(1,0,0,0,1); add(0,0,0,0,1);
    add(1,0,0,0,1); add(1,0,0,0,1); add(0,0,0,0,1); add(0,1,0,1,0);
    add(0,0,0,1,0);
    // held mode button gives a single edge; exit with nothing pending
    add(0,1,0,1,1); add(0,1,0,1,1); add(0,0,0,1,1); add(0,1,0,1,0);
    add(0,0,0,1,0);
    // tick+mode in RUN, then inc+mode with pending (+2), then tick+mode in SET
    add(1,0,0,2,0); add(0,0,0,2,0); add(1,0,0,3,0); add(0,0,0,3,0);
    add(1,1,0,4,1); add(0,0,0,4,1); add(1,0,0,4,1); add(0,0,0,4,1);
    add(0,1,1,6,0); add(0,0,0,6,0); add(0,1,0,6,1); add(0,0,0,6,1);
    add(1,1,0,0,0); add(0,0,0,0,0);

    rst_n = 1'b0;
    midnight_tick = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    #12;
    chk("reset day", {5'd0, day}, 8'd0);
    chk("reset set_mode", {7'd0, set_mode}, 8'd0);
    chk("reset letter_pos", {6'd0, letter_pos}, 8'd0);
    chk("reset digit_en", {4'd0, digit_en}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running scan straight after reset.
    for (int k = 0; k < 16; k++) begin
      check_scan(1'b0);
      @(negedge clk);
    end

    // Seven midnight ticks, ten cycles apart.
    for (int n = 1; n <= 7; n++) begin
      drive(1, 0, 0);
      chk("tick day", {5'd0, day}, 8'(n % 7));
      chk("tick set_mode", {7'd0, set_mode}, 8'd0);
      for (int w = 0; w < 9; w++) begin
        check_scan(1'b0);
        drive(0, 0, 0);
      end
      chk("tick day hold", {5'd0, day}, 8'(n % 7));
    end

    // Table vectors.
    for (int v = 0; v < vq.size(); v++) begin
      drive(vq[v].t, vq[v].m, vq[v].i);
      chk($sformatf("vec%0d day", v), {5'd0, day}, {5'd0, vq[v].d});
      chk($sformatf("vec%0d set_mode", v), {7'd0, set_mode}, {7'd0, vq[v].s});
    end

    // Blink: 8 visible, 8 blank, alternating; scanning continues throughout.
    drive(0, 1, 0);
    chk("blink enter set_mode", {7'd0, set_mode}, 8'd1);
    for (int j = 0; j < 32; j++) begin
      check_scan(((j / 8) % 2) == 1);
      drive(0, 0, 0);
    end
    drive(0, 1, 0);
    chk("blink exit set_mode", {7'd0, set_mode}, 8'd0);
    for (int j = 0; j < 12; j++) begin
      check_scan(1'b0);
      drive(0, 0, 0);
    end

    // Reach SET with day=4 and a pending tick, then reset mid-cycle.
    for (int n = 0; n < 4; n++) begin
      drive(1, 0, 0);
      drive(0, 0, 0);
    end
    chk("pre-reset day", {5'd0, day}, 8'd4);
    drive(0, 1, 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    chk("pre-reset set_mode", {7'd0, set_mode}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset day", {5'd0, day}, 8'd0);
    chk("async reset set_mode", {7'd0, set_mode}, 8'd0);
    chk("async reset digit_en", {4'd0, digit_en}, 8'd1);
    chk("async reset letter_pos", {6'd0, letter_pos}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 0);
    chk("post-reset enter", {7'd0, set_mode}, 8'd1);
    drive(0, 0, 0);
    drive(0, 1, 0);
    chk("post-reset exit set_mode", {7'd0, set_mode}, 8'd0);
    chk("post-reset pending lost", {5'd0, day}, 8'd0);
    drive(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
